// File: rtl/regfile_writeback.sv
// Dual-lane result buffer feeding a two-write-port register file.
// Results are queued in program order and drained up to two per cycle.
module regfile_writeback #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       res_valid0,
    input  logic                       res_valid1,
    input  logic [4:0]                 res_rd0,
    input  logic [4:0]                 res_rd1,
    input  logic [31:0]                res_data0,
    input  logic [31:0]                res_data1,
    output logic                       res_ready,
    output logic                       we0,
    output logic                       we1,
    output logic [4:0]                 wr_addr0,
    output logic [4:0]                 wr_addr1,
    output logic [31:0]                wr_din0,
    output logic [31:0]                wr_din1,
    output logic [31:0]                pending,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [4:0]    rd_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] head_p1;

    logic          s0;
    logic          s1;
    logic [1:0]    stored;
    logic [1:0]    drained;

    assign res_ready = !rst && !flush && (count <= CW'(DEPTH - 2));

    // Lanes targeting r0 handshake normally but never take a slot.
    assign s0      = res_valid0 && res_ready && (res_rd0 != 5'd0);
    assign s1      = res_valid1 && res_ready && (res_rd1 != 5'd0);
    assign stored  = {1'b0, s0} + {1'b0, s1};

    assign we0     = !rst && !flush && (count >= CW'(1));
    assign we1     = !rst && !flush && (count >= CW'(2));
    assign drained = {1'b0, we0} + {1'b0, we1};

    assign head_p1  = head + PW'(1);
    assign wr_addr0 = rd_mem[head];
    assign wr_din0  = data_mem[head];
    assign wr_addr1 = rd_mem[head_p1];
    assign wr_din1  = data_mem[head_p1];

    always_comb begin
        logic [PW-1:0] off;
        pending = '0;
        off     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head;
            if (CW'(off) < count)
                pending[rd_mem[i]] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(drained);
            tail  <= tail + PW'(stored);
            count <= count - CW'(drained) + CW'(stored);
        end
    end

    // Lane 1 lands right after lane 0 only when lane 0 was actually stored.
    always_ff @(posedge clk) begin
        if (s0) begin
            rd_mem[tail]   <= res_rd0;
            data_mem[tail] <= res_data0;
        end
        if (s1) begin
            rd_mem[tail + PW'(s0)]   <= res_rd1;
            data_mem[tail + PW'(s0)] <= res_data1;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: a queue of expected write-port
// entries in program order, filled on accept and consumed by a monitor.
module tb_regfile_writeback;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          res_valid0, res_valid1;
    logic [4:0]    res_rd0, res_rd1;
    logic [31:0]   res_data0, res_data1;
    logic          res_ready;
    logic          we0, we1;
    logic [4:0]    wr_addr0, wr_addr1;
    logic [31:0]   wr_din0, wr_din1;
    logic [31:0]   pending;
    logic [CW-1:0] count;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 0;

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .res_valid0 (res_valid0),
        .res_valid1 (res_valid1),
        .res_rd0    (res_rd0),
        .res_rd1    (res_rd1),
        .res_data0  (res_data0),
        .res_data1  (res_data1),
        .res_ready  (res_ready),
        .we0        (we0),
        .we1        (we1),
        .wr_addr0   (wr_addr0),
        .wr_addr1   (wr_addr1),
        .wr_din0    (wr_din0),
        .wr_din1    (wr_din1),
        .pending    (pending),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; acceptance is decided from the reference occupancy.
    task automatic step(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                        input logic fl, input logic rs);
        bit rdy;
        res_valid0 = v0; res_rd0 = r0; res_data0 = d0;
        res_valid1 = v1; res_rd1 = r1; res_data1 = d1;
        flush = fl; rst = rs;
        rdy = !rs && !fl && (exp_q.size() <= DEPTH - 2);
        @(posedge clk);
        #1;
        if (rs || fl) begin
            exp_q.delete();
        end else if (rdy) begin
            if (v0 && r0 != 5'd0) exp_q.push_back('{rd: r0, data: d0});
            if (v1 && r1 != 5'd0) exp_q.push_back('{rd: r1, data: d1});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares outputs each falling edge and retires written entries.
    initial begin
        bit          e_we0, e_we1, e_rdy;
        logic [31:0] pm;
        ent_t        e;
        @(posedge clk);
        while (!done) begin
            @(negedge clk);
            e_we0 = !rst && !flush && exp_q.size() >= 1;
            e_we1 = !rst && !flush && exp_q.size() >= 2;
            e_rdy = !rst && !flush && exp_q.size() <= DEPTH - 2;
            pm = '0;
            foreach (exp_q[k]) pm[exp_q[k].rd] = 1'b1;
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("res_ready", 32'(res_ready), 32'(e_rdy));
            chk("we0", 32'(we0), 32'(e_we0));
            chk("we1", 32'(we1), 32'(e_we1));
            chk("pending", pending, pm);
            if (e_we0) begin
                e = exp_q.pop_front();
                chk("wr_addr0", 32'(wr_addr0), 32'(e.rd));
                chk("wr_din0", wr_din0, e.data);
            end
            if (e_we1) begin
                e = exp_q.pop_front();
                chk("wr_addr1", 32'(wr_addr1), 32'(e.rd));
                chk("wr_din1", wr_din1, e.data);
            end
        end
    end

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        step(1, 5'd5, 32'h11, 0, 0, 0, 0, 0);
        idle(2);
        step(1, 5'd3, 32'hA, 1, 5'd3, 32'hB, 0, 0);
        idle(2);
        step(1, 5'd0, 32'hFF, 1, 5'd7, 32'h22, 0, 0);
        idle(2);
        step(1, 5'd9, 32'h90, 1, 5'd10, 32'hA0, 0, 0);
        step(1, 5'd11, 32'hB0, 1, 5'd12, 32'hC0, 1, 0);
        idle(2);
        for (int i = 0; i < 10; i++)
            step(1, 5'(i + 1), 32'h100 + 32'(i), 0, 0, 0, 0, 0);
        step(1, 5'd4, 32'h44, 1, 5'd6, 32'h66, 0, 0);
        step(1, 5'd8, 32'h88, 1, 5'd2, 32'h22, 0, 1);
        idle(2);
        for (int i = 0; i < 400; i++) begin
            logic [4:0] r0, r1;
            r0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            r1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            step(1'($urandom), r0, $urandom, 1'($urandom), r1, $urandom,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
        end
        idle(3);
        done = 1;
        @(posedge clk);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 Parameter: DEPTH, 4, number of buffered result entries; power of two, minimum 2.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, synchronous and active-high.
REQ-004 Port: flush  in  1  discard all buffered entries (misprediction recovery).
REQ-005 Port: res_valid0, res_valid1  in  1 each  result lanes; lane 0 older than lane 1 in program order.
REQ-006 Port: res_rd0, res_rd1  in  5 each  destination register per lane.
REQ-007 Port: res_data0, res_data1  in  32 each  result value per lane.
REQ-008 Port: res_ready  out  1  both lanes accepted this cycle when high.
REQ-009 Port: we0, we1  out  1 each  register-file write enables; port 1 carries the younger entry.
REQ-010 Port: wr_addr0, wr_addr1  out  5 each  register-file write addresses.
REQ-011 Port: wr_din0, wr_din1  out  32 each  register-file write data.
REQ-012 Port: pending  out  32  bit r high while any buffered entry targets register r.
REQ-013 Port: count  out  $clog2(DEPTH+1)  number of buffered entries.

Function
REQ-014 Storage: circular FIFO of DEPTH entries {rd, data}; head and tail pointers wrap modulo DEPTH.
REQ-015 res_ready = !flush && (count <= DEPTH-2), from registered count only; no drain credit taken.
REQ-016 A lane is accepted on an edge where res_valid and res_ready are high.
REQ-017 Accepted lanes with rd != 0 are written at tail in program order: lane 0 first, lane 1 next; the tail advances by the number stored.
REQ-018 Accepted lanes with rd == 0 complete the handshake but are discarded; they neither occupy a slot nor set pending.
REQ-019 Only lane 1 storable: it is written at tail and the tail advances by 1.
REQ-020 Drain is unconditional, up to 2 entries per cycle: we0 = (count >= 1) && !flush; we1 = (count >= 2) && !flush.
REQ-021 The head entry drives wr_addr0/wr_din0; entry head+1 (mod DEPTH) drives wr_addr1/wr_din1.
REQ-022 All write-port outputs are combinational from registered state only, with no path from res_* inputs.
REQ-023 On each non-flush edge, the head advances by we0+we1.
REQ-024 On each non-flush edge, count_next = count - (we0+we1) + stored.
REQ-025 Latency: an entry stored at edge N is presented on the write port during the cycle after N when at most one older entry remains, so the register file commits it at edge N+1.
REQ-026 Ordering: entries leave in acceptance order. Two same-cycle entries with equal rd appear as older on port 0 and younger on port 1, so the port-1 write wins.
REQ-027 pending is recomputed combinationally from valid entries between head and tail; pending[0] is always 0.
REQ-028 flush high at an edge: head, tail and count become 0; no entry is accepted or written in that cycle.
REQ-029 Simultaneous drain and accept at full occupancy cannot overflow, because acceptance requires count <= DEPTH-2.
REQ-030 Wrap-around: an entry stored at index DEPTH-1 followed by one at index 0 drains in that order without gap.

Reset
REQ-031 rst high at an edge sets head = 0, tail = 0 and count = 0; rst takes priority over flush and over handshakes.
REQ-032 During and after reset until the first accept: we0 = we1 = 0, pending = 0, res_ready = 1 while rst is low.
REQ-033 Entry storage contents need no reset; write addresses and data are don't-care while the matching we is 0.
REQ-034 Reset asserted mid-operation discards all buffered entries; no write is issued in the reset cycle.

Verification
REQ-035 After reset, lane 0 {rd=5, data=0x11} alone at edge 1 -> next cycle we0=1, wr_addr0=5, wr_din0=0x11, we1=0, pending[5]=1; count returns to 0 after edge 2.
REQ-036 Both lanes {rd=3, 0xA}, {rd=3, 0xB} at one edge -> next cycle we0=1 addr 3 data 0xA, we1=1 addr 3 data 0xB; register 3 ends at 0xB.
REQ-037 Lanes {rd=0, 0xFF}, {rd=7, 0x22} -> handshake completes, count=1, port 0 writes rd 7, no write to rd 0.
REQ-038 DEPTH=4, count=3 -> res_ready=0 and valid input is ignored; the next cycle drains 2 and count=1, res_ready=1.
REQ-039 Buffer holding 2 entries, flush=1 -> we0=we1=0 that cycle; count=0 and pending=0 next cycle; concurrent valid input is not accepted.
REQ-040 Stream 10 single-lane entries with tail crossing index 3->0 -> write-port sequence matches input order exactly.
